// File: rtl/duck_pos_arbiter.sv
// Round-robin arbiter that lets two duck requesters share one position generator.
// Moore FSM IDLE -> START -> WAIT -> DONE; a generator that never answers is abandoned after TIMEOUT WAIT cycles.
module duck_pos_arbiter #(
    parameter logic [7:0]        TIMEOUT = 8'd200,
    parameter logic signed [9:0] HIDE_Y  = -10'sd10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req1,
    input  logic               req2,
    output logic               gen_start,
    input  logic               gen_done,
    input  logic [9:0]         gen_x,
    input  logic signed [9:0]  gen_y,
    output logic               ack1,
    output logic               ack2,
    output logic [9:0]         pos_x1,
    output logic [9:0]         pos_x2,
    output logic signed [9:0]  pos_y1,
    output logic signed [9:0]  pos_y2,
    output logic               busy,
    output logic               err,
    output logic [1:0]         o_dbg_state
);

    // Handshake: req1/req2 are levels held until the matching one-cycle ack;
    // gen_start is a one-cycle request, gen_done a one-cycle answer carrying gen_x/gen_y.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LP_WAIT_LAST = TIMEOUT - 8'd1;

    state_t             r_state;
    logic               r_grant2;
    logic               r_last2;
    logic [7:0]         r_wait_cnt;
    logic               r_err;
    logic [9:0]         r_pos_x1;
    logic [9:0]         r_pos_x2;
    logic signed [9:0]  r_pos_y1;
    logic signed [9:0]  r_pos_y2;
    logic               w_pick2;

    // Duck 2 wins when alone, or on a tie when duck 1 was served last.
    assign w_pick2 = req2 & (~req1 | ~r_last2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant2   <= 1'b0;
            r_last2    <= 1'b1;
            r_wait_cnt <= 8'd0;
            r_err      <= 1'b0;
            r_pos_x1   <= 10'd0;
            r_pos_x2   <= 10'd0;
            r_pos_y1   <= HIDE_Y;
            r_pos_y2   <= HIDE_Y;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req1 | req2) begin
                        r_grant2 <= w_pick2;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    r_wait_cnt <= 8'd0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // An answer on the final allowed cycle still counts as success.
                    if (gen_done) begin
                        if (r_grant2) begin
                            r_pos_x2 <= gen_x;
                            r_pos_y2 <= gen_y;
                        end else begin
                            r_pos_x1 <= gen_x;
                            r_pos_y1 <= gen_y;
                        end
                        r_state <= S_DONE;
                    end else if (r_wait_cnt == LP_WAIT_LAST) begin
                        r_err   <= 1'b1;
                        r_last2 <= r_grant2;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_last2 <= r_grant2;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gen_start   = (r_state == S_START);
    assign ack1        = (r_state == S_DONE) & ~r_grant2;
    assign ack2        = (r_state == S_DONE) &  r_grant2;
    assign busy        = (r_state != S_IDLE);
    assign err         = r_err;
    assign pos_x1      = r_pos_x1;
    assign pos_x2      = r_pos_x2;
    assign pos_y1      = r_pos_y1;
    assign pos_y2      = r_pos_y2;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_duck_pos_arbiter.sv
// Self-checking bench for duck_pos_arbiter: reset, single request, tie fairness,
// timeout, done-on-last-cycle, random traffic, reset mid-WAIT and a spurious gen_done.
module tb_duck_pos_arbiter;

    localparam int         TO_I = 4;
    localparam logic [9:0] HIDE = 10'h3F6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req1 = 1'b0;
    logic              req2 = 1'b0;
    logic              gen_done = 1'b0;
    logic [9:0]        gen_x = 10'd0;
    logic signed [9:0] gen_y = 10'sd0;
    logic              gen_start, ack1, ack2, busy, err;
    logic [9:0]        pos_x1, pos_x2;
    logic signed [9:0] pos_y1, pos_y2;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [42:0] exp_q[$];

    typedef struct {
        logic        r1;
        logic        r2;
        int          dly;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [42:0] e;
    } vec_t;

    vec_t tv[9];

    duck_pos_arbiter #(.TIMEOUT(8'(TO_I)), .HIDE_Y(-10'sd10)) dut (
        .clk(clk), .reset(reset), .req1(req1), .req2(req2),
        .gen_start(gen_start), .gen_done(gen_done), .gen_x(gen_x), .gen_y(gen_y),
        .ack1(ack1), .ack2(ack2), .pos_x1(pos_x1), .pos_x2(pos_x2),
        .pos_y1(pos_y1), .pos_y2(pos_y2), .busy(busy), .err(err),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [42:0] mk(input logic a1, input logic a2, input logic e,
                                       input logic [9:0] x1, input logic [9:0] y1,
                                       input logic [9:0] x2, input logic [9:0] y2);
        return {a1, a2, e, x1, y1, x2, y2};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req1 = 1'b0; req2 = 1'b0; gen_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction: raise reqs in IDLE, answer in WAIT cycle dly (0 = never),
    // then compare the pulse cycle against the scoreboard head.
    task automatic run_vec(input string tag, input logic r1, input logic r2, input int dly,
                           input logic [9:0] x, input logic [9:0] y, input logic [42:0] e);
        int          exp_cyc;
        int          cyc;
        logic        got;
        logic [42:0] obs;
        logic [42:0] head;
        exp_q.push_back(e);
        exp_cyc = (dly >= 1 && dly <= TO_I) ? dly + 2 : TO_I + 2;
        @(negedge clk);
        req1 = r1; req2 = r2;
        @(posedge clk); #1;
        chk({tag, " gen_start"}, {63'd0, gen_start}, 64'd1);
        got = 1'b0;
        obs = '0;
        cyc = 1;
        while (!got && cyc < 300) begin
            @(negedge clk);
            gen_done = (dly >= 1) && (cyc - 1 == dly);
            gen_x = gen_done ? x : 10'($urandom_range(0, 1023));
            gen_y = gen_done ? y : 10'($urandom_range(0, 1023));
            @(posedge clk); #1;
            cyc++;
            if (ack1 | ack2 | err) begin
                got = 1'b1;
                obs = mk(ack1, ack2, err, pos_x1, pos_y1, pos_x2, pos_y2);
            end
        end
        @(negedge clk);
        gen_done = 1'b0; req1 = 1'b0; req2 = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s no_pulse: got none expected ack/err within 300 cycles", tag);
            void'(exp_q.pop_front());
        end else begin
            head = exp_q.pop_front();
            chk({tag, " result"}, {21'd0, obs}, {21'd0, head});
            chk({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
        end
        @(posedge clk); #1;
        chk({tag, " idle_after"}, {60'd0, busy, ack1, ack2, err}, 64'd0);
    endtask

    initial begin
        logic        m_last2, w2, a1, a2, me;
        logic [9:0]  m_x1, m_y1, m_x2, m_y2, rx, ry;
        logic [1:0]  rr;
        int          rd;
        logic        seen;

        // Ties first so the order from reset is 1,2,1,2; then timeout on duck 2,
        // next tie to duck 1, done on the last WAIT cycle and extreme values.
        tv[0] = '{1'b1, 1'b1, 1, 10'd10,   10'd20,      mk(1,0,0, 10'd10, 10'd20, 10'd0, HIDE)};
        tv[1] = '{1'b1, 1'b1, 1, 10'd11,   -10'sd21,    mk(0,1,0, 10'd10, 10'd20, 10'd11, -10'sd21)};
        tv[2] = '{1'b1, 1'b1, 1, 10'd12,   10'd22,      mk(1,0,0, 10'd12, 10'd22, 10'd11, -10'sd21)};
        tv[3] = '{1'b1, 1'b1, 1, 10'd13,   -10'sd23,    mk(0,1,0, 10'd12, 10'd22, 10'd13, -10'sd23)};
        tv[4] = '{1'b0, 1'b1, 0, 10'd99,   10'd99,      mk(0,0,1, 10'd12, 10'd22, 10'd13, -10'sd23)};
        tv[5] = '{1'b1, 1'b1, 1, 10'd14,   10'd24,      mk(1,0,0, 10'd14, 10'd24, 10'd13, -10'sd23)};
        tv[6] = '{1'b0, 1'b1, 4, 10'd1023, 10'h200,     mk(0,1,0, 10'd14, 10'd24, 10'd1023, 10'h200)};
        tv[7] = '{1'b1, 1'b0, 3, 10'd512,  10'd511,     mk(1,0,0, 10'd512, 10'd511, 10'd1023, 10'h200)};
        tv[8] = '{1'b0, 1'b1, 2, 10'd5,    -10'sd1,     mk(0,1,0, 10'd512, 10'd511, 10'd5, -10'sd1)};

        do_reset();
        chk("reset ctrl", {59'd0, busy, gen_start, ack1, ack2, err}, 64'd0);
        chk("reset state", {62'd0, dbg_state}, 64'd0);
        chk("reset pos", {21'd0, pos_x1, pos_y1, pos_x2, pos_y2}, {21'd0, 10'd0, HIDE, 10'd0, HIDE});

        run_vec("single", 1'b1, 1'b0, 2, 10'd300, -10'sd5, mk(1,0,0, 10'd300, -10'sd5, 10'd0, HIDE));

        do_reset();
        for (int i = 0; i < 9; i++)
            run_vec($sformatf("vec%0d", i), tv[i].r1, tv[i].r2, tv[i].dly, tv[i].x, tv[i].y, tv[i].e);

        m_x1 = tv[8].e[39:30]; m_y1 = tv[8].e[29:20];
        m_x2 = tv[8].e[19:10]; m_y2 = tv[8].e[9:0];
        m_last2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rr = 2'($urandom_range(1, 3));
            rd = $urandom_range(0, TO_I);
            rx = 10'($urandom_range(0, 1023));
            ry = 10'($urandom_range(0, 1023));
            w2 = rr[1] & (~rr[0] | ~m_last2);
            me = (rd == 0);
            a1 = ~me & ~w2;
            a2 = ~me & w2;
            if (a1) begin m_x1 = rx; m_y1 = ry; end
            if (a2) begin m_x2 = rx; m_y2 = ry; end
            m_last2 = w2;
            run_vec($sformatf("rnd%0d", i), rr[0], rr[1], rd, rx, ry,
                    mk(a1, a2, me, m_x1, m_y1, m_x2, m_y2));
        end

        // Reset while waiting, then a late answer that must be ignored.
        @(negedge clk);
        req1 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstwait in_wait", {62'd0, dbg_state}, 64'd2);
        @(negedge clk);
        reset = 1'b1; req1 = 1'b0;
        @(negedge clk);
        reset = 1'b0; gen_done = 1'b1; gen_x = 10'd77; gen_y = 10'sd9;
        seen = 1'b0;
        @(posedge clk); #1;
        seen = seen | ack1 | ack2 | err | gen_start;
        @(negedge clk);
        gen_done = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            seen = seen | ack1 | ack2 | err | gen_start | busy;
        end
        chk("rstwait no_pulse", {63'd0, seen}, 64'd0);
        chk("rstwait state", {62'd0, dbg_state}, 64'd0);
        chk("rstwait pos", {21'd0, pos_x1, pos_y1, pos_x2, pos_y2}, {21'd0, 10'd0, HIDE, 10'd0, HIDE});

        // Spurious answer while idle.
        @(negedge clk);
        gen_done = 1'b1; gen_x = 10'd77; gen_y = 10'sd3;
        @(negedge clk);
        gen_done = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | ack1 | ack2 | err | gen_start | busy;
        end
        chk("spurious no_pulse", {63'd0, seen}, 64'd0);
        chk("spurious pos", {21'd0, pos_x1, pos_y1, pos_x2, pos_y2}, {21'd0, 10'd0, HIDE, 10'd0, HIDE});

        run_vec("post", 1'b0, 1'b1, 1, 10'd42, -10'sd42, mk(0,1,0, 10'd0, HIDE, 10'd42, -10'sd42));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
